// File: rtl/rob.sv
// In-order retirement buffer feeding the architectural regfile write port.
// Latency: writeback at cycle t can retire at t+1 at the earliest; one retire per cycle.
// Backpressure: enq_ready drops while full, even if an entry retires that same cycle.
module rob #(
    parameter int N_ENTRIES      = 16,
    parameter int ENTRY_WIDTH    = 32,
    parameter int ARF_ADDR_WIDTH = 5,
    localparam int ID_WIDTH      = $clog2(N_ENTRIES),
    localparam int CTR_WIDTH     = ID_WIDTH + 1
) (
    input  logic                      clk,
    input  logic                      rst_aL,
    input  logic                      flush,
    input  logic                      enq_valid,
    output logic                      enq_ready,
    input  logic                      enq_wr_rd,
    input  logic [ARF_ADDR_WIDTH-1:0] enq_rd_addr,
    output logic [ID_WIDTH-1:0]       enq_id,
    input  logic                      wb_valid,
    input  logic [ID_WIDTH-1:0]       wb_id,
    input  logic [ENTRY_WIDTH-1:0]    wb_data,
    output logic                      rf_wr_en,
    output logic [ARF_ADDR_WIDTH-1:0] rf_wr_addr,
    output logic [ENTRY_WIDTH-1:0]    rf_wr_data,
    output logic                      empty,
    output logic [CTR_WIDTH-1:0]      count
);

    typedef struct packed {
        logic                      valid;
        logic                      done;
        logic                      wr_rd;
        logic [ARF_ADDR_WIDTH-1:0] rd_addr;
        logic [ENTRY_WIDTH-1:0]    data;
    } entry_t;

    entry_t                ent_q [N_ENTRIES];
    entry_t                ent_d [N_ENTRIES];
    logic [ID_WIDTH-1:0]   head_q, head_d;
    logic [ID_WIDTH-1:0]   tail_q, tail_d;
    logic [CTR_WIDTH-1:0]  count_q, count_d;

    entry_t                head_ent;
    logic                  enq_fire;
    logic                  wb_fire;
    logic                  retire;

    assign head_ent  = ent_q[head_q];

    // Ready is based on the registered count only; a same-cycle retire does not free a slot early.
    assign enq_ready = (count_q != CTR_WIDTH'(N_ENTRIES));

    // Flush dominates every other event in its cycle.
    assign enq_fire  = enq_valid && enq_ready && !flush;
    assign wb_fire   = wb_valid && ent_q[wb_id].valid && !ent_q[wb_id].done && !flush;
    assign retire    = head_ent.valid && head_ent.done && !flush;

    // Writes to x0 and non-writing instructions retire silently.
    assign rf_wr_en   = retire && head_ent.wr_rd && (head_ent.rd_addr != '0);
    assign rf_wr_addr = head_ent.rd_addr;
    assign rf_wr_data = head_ent.data;

    assign enq_id = tail_q;
    assign count  = count_q;
    assign empty  = (count_q == '0);

    // Per-entry next state: flush clears, else retire, writeback and allocate touch distinct slots.
    always_comb begin
        for (int i = 0; i < N_ENTRIES; i++) begin
            ent_d[i] = ent_q[i];
            if (flush) begin
                ent_d[i].valid = 1'b0;
                ent_d[i].done  = 1'b0;
            end else begin
                if (retire && (head_q == ID_WIDTH'(i))) begin
                    ent_d[i].valid = 1'b0;
                    ent_d[i].done  = 1'b0;
                end
                if (wb_fire && (wb_id == ID_WIDTH'(i))) begin
                    ent_d[i].done = 1'b1;
                    ent_d[i].data = wb_data;
                end
                if (enq_fire && (tail_q == ID_WIDTH'(i))) begin
                    ent_d[i].valid   = 1'b1;
                    ent_d[i].done    = 1'b0;
                    ent_d[i].wr_rd   = enq_wr_rd;
                    ent_d[i].rd_addr = enq_rd_addr;
                end
            end
        end
    end

    // Pointer and occupancy next state; pointers wrap naturally at the power-of-2 depth.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (retire) begin
                head_d = head_q + ID_WIDTH'(1);
            end
            if (enq_fire) begin
                tail_d = tail_q + ID_WIDTH'(1);
            end
            case ({enq_fire, retire})
                2'b10:   count_d = count_q + CTR_WIDTH'(1);
                2'b01:   count_d = count_q - CTR_WIDTH'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State registers with synchronous active-low reset clearing every entry field.
    always_ff @(posedge clk) begin
        if (!rst_aL) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < N_ENTRIES; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            for (int i = 0; i < N_ENTRIES; i++) begin
                ent_q[i] <= ent_d[i];
            end
        end
    end

endmodule
